codec_clkgen: RTL and testbench
===============================

Name: codec_clkgen

Overview:
- Parametrised clock/frame generator for the WM8731 serial audio interface.
- Derives MCLK, BCLK and LRCLK (DACLRC/ADCLRC) from the system clock.
- Provides single-cycle strobes and a bit index so the serialiser and deserialiser shift data in lock-step.
- Sits between the system clock and the audio data path; replaces the fixed divide-by-4 MCLK / fixed BCLK generator.

Parameters:
- MCLK_HALF, 2, clk cycles per MCLK half-period (>=1); default gives MCLK = clk/4.
- BCLK_HALF, 4, MCLK periods per BCLK half-period (>=1); default gives BCLK = MCLK/8.
- SLOT_BITS, 32, BCLK periods per channel slot (>=2); frame = 2*SLOT_BITS BCLK periods.
- IDXW, $clog2(SLOT_BITS), width of bit_idx.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low; one clock domain only.
- en  input  1  run enable, sampled synchronously.
- mclk  output  1  codec master clock.
- bclk  output  1  codec bit clock.
- lrclk  output  1  left/right clock; 0 = left slot, 1 = right slot.
- bclk_rise  output  1  one-clk pulse, same cycle bclk register goes 0->1.
- bclk_fall  output  1  one-clk pulse, same cycle bclk register goes 1->0.
- frame_start  output  1  one-clk pulse marking the left-channel MSB (see Behaviour).
- bit_idx  output  IDXW  bit position of the current slot; SLOT_BITS-1 = MSB, counts down.

Behaviour:
- Reset:
  - Asserted (reset=0): immediately mclk=bclk=lrclk=0, all strobes=0, bit_idx=SLOT_BITS-1, all internal counters=0.
- Outputs:
  - All outputs are registered; no combinational paths to outputs; glitch-free.
- MCLK divider:
  - mcnt counts 0..MCLK_HALF-1 while en=1.
  - On wrap, mcnt returns to 0 and mclk toggles.
  - First mclk rise occurs MCLK_HALF clk cycles after the first enabled cycle.
- BCLK divider:
  - bcnt counts 0..BCLK_HALF-1, incrementing only on cycles where mclk toggles 1->0.
  - On wrap, bclk toggles, so BCLK edges coincide with MCLK falling edges.
  - bclk_rise / bclk_fall are asserted in the same cycle as the bclk register transition.
- Slot counter:
  - On each bclk_fall, bit_idx decrements.
  - At 0 it wraps to SLOT_BITS-1.
- LRCLK:
  - Toggles on the bclk_fall at which bit_idx wraps to SLOT_BITS-1 (left-justified timing).
  - frame_start is asserted with that bclk_fall when lrclk becomes 0.
- en handling:
  - en=0: next clk forces the full reset state synchronously (clocks low, counters cleared).
  - en=1 again: restarts from reset state, with timing identical to restart after reset release.
  - en falling mid-BCLK-period truncates the period; no minimum-width guarantee on the truncated pulse.
- Simultaneous events:
  - A wrap of mcnt, bcnt and bit_idx in the same cycle is legal; all registers update in that one cycle.
  - en=0 overrides any wrap.
- Frame timing at defaults:
  - MCLK period 4 clk; BCLK period 32 clk; frame 2048 clk.
- Counter sizing:
  - mcnt width $clog2(MCLK_HALF) (min 1); bcnt width $clog2(BCLK_HALF) (min 1).
  - No overflow beyond these ranges.

Optional Feature:
- Macro: CODEC_CLKGEN_I2S_EN.
- Defined (I2S timing):
  - lrclk toggles one BCLK period before the MSB, i.e. on the bclk_fall at which bit_idx becomes 0.
  - bit_idx and frame_start timing are unchanged.
  - frame_start therefore follows the lrclk falling edge by exactly one BCLK period.
- Not defined: left-justified timing as in Behaviour; lrclk edge and frame_start coincide.

Test Plan:
1. Defaults, release reset, en=1 -> mclk high 2 clk / low 2 clk; bclk period 32 clk, 50% duty; every bclk edge coincides with an mclk falling edge; lrclk period 2048 clk.
2. Defaults, run 3 frames -> bit_idx cycles 31..0 per slot; exactly one frame_start per 2048 clk, coinciding with lrclk 1->0 and bit_idx=31; bclk_rise/bclk_fall each exactly one clk wide.
3. Defaults, drop en mid right slot (bit_idx=12) -> next clk: all clocks 0, bit_idx=31, no strobes. Re-assert en -> waveform identical to test 1.
4. Assert reset between clk edges mid-frame -> outputs 0 immediately, without waiting for a clk edge. Release -> restart identical to test 1.
5. MCLK_HALF=1, BCLK_HALF=1, SLOT_BITS=16 -> mclk = clk/2, bclk = clk/4, frame = 128 clk, bit_idx 15..0.
6. CODEC_CLKGEN_I2S_EN defined, defaults -> lrclk falls on the bclk_fall where bit_idx becomes 0; frame_start follows 32 clk later; lrclk period still 2048 clk.

Source files
------------

// File: rtl/codec_clkgen_if.sv
// Purpose : bundles the run enable and the generated codec clocks/strobes of codec_clkgen.
// Latency : n/a (signal bundle only).
// Backpressure: none; a free-running timing source with no handshake.
// Ports   : en (run enable, into generator); mclk, bclk, lrclk, bclk_rise, bclk_fall,
//           frame_start, bit_idx[IDXW-1:0] (out of generator).
// Modports: master = clock generator side, slave = serialiser/deserialiser side.
interface codec_clkgen_if #(
  parameter int IDXW = 5
);
  logic            en;
  logic            mclk;
  logic            bclk;
  logic            lrclk;
  logic            bclk_rise;
  logic            bclk_fall;
  logic            frame_start;
  logic [IDXW-1:0] bit_idx;

  modport master (
    input  en,
    output mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, bit_idx
  );

  modport slave (
    output en,
    input  mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, bit_idx
  );
endinterface

// File: rtl/codec_clkgen.sv
// Purpose : WM8731 MCLK/BCLK/LRCLK generator with bit strobes and slot bit index.
// Latency : all outputs registered; first mclk rise MCLK_HALF clk cycles after en is sampled high.
// Backpressure: none; free-running while en=1, en=0 forces the reset state on the next clk.
// Ports   : clk (system clock), reset (async, active-low), bus (codec_clkgen_if.master:
//           en in; mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, bit_idx out).
// Option  : define CODEC_CLKGEN_I2S_EN for I2S framing (lrclk leads the MSB by one BCLK);
//           left-justified framing otherwise.
module codec_clkgen #(
  parameter int MCLK_HALF = 2,
  parameter int BCLK_HALF = 4,
  parameter int SLOT_BITS = 32,
  parameter int IDXW      = $clog2(SLOT_BITS)
) (
  input logic          clk,
  input logic          reset,
  codec_clkgen_if.master bus
);
  localparam int MW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int BW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  localparam logic [MW-1:0]   MCNT_LAST = MW'(MCLK_HALF - 1);
  localparam logic [BW-1:0]   BCNT_LAST = BW'(BCLK_HALF - 1);
  localparam logic [IDXW-1:0] IDX_MSB   = IDXW'(SLOT_BITS - 1);

  logic [MW-1:0]   mcnt_q;
  logic [BW-1:0]   bcnt_q;
  logic [IDXW-1:0] bit_idx_q;
  logic            mclk_q;
  logic            bclk_q;
  logic            lrclk_q;
  logic            bclk_rise_q;
  logic            bclk_fall_q;
  logic            frame_start_q;

  // Event chain: every BCLK edge is a qualified MCLK falling edge, every slot
  // step is a qualified BCLK falling edge, so all of them can land in one cycle.
  logic mcnt_wrap;
  logic mclk_fall_evt;
  logic bclk_tgl;
  logic bclk_fall_evt;
  logic idx_wrap;
  logic lr_tgl;
  logic frame_evt;

  assign mcnt_wrap     = (mcnt_q == MCNT_LAST);
  assign mclk_fall_evt = mcnt_wrap & mclk_q;
  assign bclk_tgl      = mclk_fall_evt & (bcnt_q == BCNT_LAST);
  assign bclk_fall_evt = bclk_tgl & bclk_q;
  assign idx_wrap      = bclk_fall_evt & (bit_idx_q == '0);

`ifdef CODEC_CLKGEN_I2S_EN
  // I2S: lrclk moves one BCLK ahead of the MSB, so at the slot wrap lrclk
  // already shows the new slot; the left slot starts where lrclk is low.
  assign lr_tgl    = bclk_fall_evt & (bit_idx_q == IDXW'(1));
  assign frame_evt = idx_wrap & ~lrclk_q;
`else
  // Left-justified: lrclk moves together with the MSB, so at the slot wrap
  // lrclk still shows the old slot; a left slot follows a high lrclk.
  assign lr_tgl    = idx_wrap;
  assign frame_evt = idx_wrap & lrclk_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcnt_q        <= '0;
      bcnt_q        <= '0;
      bit_idx_q     <= IDX_MSB;
      mclk_q        <= 1'b0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      bclk_rise_q   <= 1'b0;
      bclk_fall_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (!bus.en) begin
      // Synchronous stop: identical to the reset state so a restart replays
      // exactly the same waveform as a release from reset.
      mcnt_q        <= '0;
      bcnt_q        <= '0;
      bit_idx_q     <= IDX_MSB;
      mclk_q        <= 1'b0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      bclk_rise_q   <= 1'b0;
      bclk_fall_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      if (mcnt_wrap) begin
        mcnt_q <= '0;
        mclk_q <= ~mclk_q;
      end else begin
        mcnt_q <= mcnt_q + MW'(1);
      end

      if (mclk_fall_evt) begin
        bcnt_q <= (bcnt_q == BCNT_LAST) ? '0 : bcnt_q + BW'(1);
      end

      if (bclk_tgl) begin
        bclk_q <= ~bclk_q;
      end
      // Strobes mark the cycle the bclk register itself changes.
      bclk_rise_q <= bclk_tgl & ~bclk_q;
      bclk_fall_q <= bclk_tgl & bclk_q;

      if (bclk_fall_evt) begin
        bit_idx_q <= idx_wrap ? IDX_MSB : bit_idx_q - IDXW'(1);
      end

      if (lr_tgl) begin
        lrclk_q <= ~lrclk_q;
      end
      frame_start_q <= frame_evt;
    end
  end

  assign bus.mclk        = mclk_q;
  assign bus.bclk        = bclk_q;
  assign bus.lrclk       = lrclk_q;
  assign bus.bclk_rise   = bclk_rise_q;
  assign bus.bclk_fall   = bclk_fall_q;
  assign bus.frame_start = frame_start_q;
  assign bus.bit_idx     = bit_idx_q;
endmodule

// File: tb/tb_codec_clkgen.sv
// Purpose : self-checking bench for codec_clkgen (default parameters and a fast
//           MCLK_HALF=1/BCLK_HALF=1/SLOT_BITS=16 build side by side).
// Latency : n/a.
// Backpressure: n/a.
module tb_codec_clkgen;
`ifdef CODEC_CLKGEN_I2S_EN
  localparam bit I2S = 1'b1;
`else
  localparam bit I2S = 1'b0;
`endif

  logic clk;
  logic reset;

  codec_clkgen_if #(.IDXW(5)) a_if ();
  codec_clkgen_if #(.IDXW(4)) b_if ();

  codec_clkgen #(.MCLK_HALF(2), .BCLK_HALF(4), .SLOT_BITS(32), .IDXW(5)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
  );

  codec_clkgen #(.MCLK_HALF(1), .BCLK_HALF(1), .SLOT_BITS(16), .IDXW(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected state right after the n-th enabled clk edge (n=0: before any edge).
  typedef struct {
    int   n;
    logic mclk;
    logic bclk;
    logic lr_lj;
    logic lr_i2s;
    logic rise;
    logic fall;
    logic fs;
    int   idx;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];
  int   ia, ib;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  function automatic vec_t mk(int n, logic m, logic b, logic llj, logic li2s,
                              logic r, logic f, logic fs, int idx);
    vec_t v;
    v.n = n; v.mclk = m; v.bclk = b; v.lr_lj = llj; v.lr_i2s = li2s;
    v.rise = r; v.fall = f; v.fs = fs; v.idx = idx;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_en(input logic v);
    a_if.en = v;
    b_if.en = v;
  endtask

  task automatic check_vecs(input int n);
    while (ia < va.size() && va[ia].n == n) begin
      chk($sformatf("A_clocks@%0d", n),
          {26'd0, a_if.mclk, a_if.bclk, a_if.lrclk, a_if.bclk_rise, a_if.bclk_fall, a_if.frame_start},
          {26'd0, va[ia].mclk, va[ia].bclk, (I2S ? va[ia].lr_i2s : va[ia].lr_lj),
           va[ia].rise, va[ia].fall, va[ia].fs});
      chk($sformatf("A_bit_idx@%0d", n), 32'(a_if.bit_idx), 32'(va[ia].idx));
      ia++;
    end
    while (ib < vb.size() && vb[ib].n == n) begin
      chk($sformatf("B_clocks@%0d", n),
          {26'd0, b_if.mclk, b_if.bclk, b_if.lrclk, b_if.bclk_rise, b_if.bclk_fall, b_if.frame_start},
          {26'd0, vb[ib].mclk, vb[ib].bclk, (I2S ? vb[ib].lr_i2s : vb[ib].lr_lj),
           vb[ib].rise, vb[ib].fall, vb[ib].fs});
      chk($sformatf("B_bit_idx@%0d", n), 32'(b_if.bit_idx), 32'(vb[ib].idx));
      ib++;
    end
  endtask

  // Called with en just raised (or reset just released); steps n_end edges.
  task automatic run(input int n_end);
    ia = 0;
    ib = 0;
    cyc = 0;
    check_vecs(0);
    for (int n = 1; n <= n_end; n++) begin
      @(posedge clk);
      cyc = n;
      #1;
      check_vecs(n);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_A_clocks"},
        {26'd0, a_if.mclk, a_if.bclk, a_if.lrclk, a_if.bclk_rise, a_if.bclk_fall, a_if.frame_start}, 32'd0);
    chk({tag, "_A_bit_idx"}, 32'(a_if.bit_idx), 32'd31);
    chk({tag, "_B_clocks"},
        {26'd0, b_if.mclk, b_if.bclk, b_if.lrclk, b_if.bclk_rise, b_if.bclk_fall, b_if.frame_start}, 32'd0);
    chk({tag, "_B_bit_idx"}, 32'(b_if.bit_idx), 32'd15);
  endtask

  // Continuous checks on the default instance while a run is in progress.
  logic       mon_on = 1'b0;
  logic       mon_primed = 1'b0;
  logic       pm, pb, pl;
  logic [4:0] pidx;
  int         last_lr_rise = -1;
  int         last_lr_fall = -1;
  int         fs_cnt = 0;

  always @(negedge clk) begin
    if (!mon_on) begin
      mon_primed   = 1'b0;
      last_lr_rise = -1;
      last_lr_fall = -1;
    end else begin
      if (mon_primed) begin
        chk("bclk_rise_strobe", 32'(a_if.bclk_rise), 32'(a_if.bclk & ~pb));
        chk("bclk_fall_strobe", 32'(a_if.bclk_fall), 32'(~a_if.bclk & pb));
        if (a_if.bclk != pb)
          chk($sformatf("bclk_edge_on_mclk_fall@%0d", cyc), {30'd0, pm, a_if.mclk}, 32'd2);
        if (a_if.bclk_fall)
          chk($sformatf("bit_idx_step@%0d", cyc), 32'(a_if.bit_idx), (pidx == 5'd0) ? 32'd31 : 32'(pidx) - 32'd1);
        else
          chk($sformatf("bit_idx_hold@%0d", cyc), 32'(a_if.bit_idx), 32'(pidx));
        if (a_if.lrclk && !pl) begin
          if (last_lr_rise >= 0)
            chk("lrclk_period", 32'(cyc - last_lr_rise), 32'd2048);
          last_lr_rise = cyc;
        end
        if (!a_if.lrclk && pl)
          last_lr_fall = cyc;
        if (a_if.frame_start) begin
          fs_cnt++;
          chk($sformatf("frame_start_idx@%0d", cyc), 32'(a_if.bit_idx), 32'd31);
          chk($sformatf("frame_start_lrclk@%0d", cyc), 32'(a_if.lrclk), 32'd0);
          chk($sformatf("frame_start_after_lr_fall@%0d", cyc),
              32'(cyc - last_lr_fall), I2S ? 32'd32 : 32'd0);
        end
      end
      pm = a_if.mclk;
      pb = a_if.bclk;
      pl = a_if.lrclk;
      pidx = a_if.bit_idx;
      mon_primed = 1'b1;
    end
  end

  initial begin
    //          n     m  b  lj i2s r  f  fs idx
    va.push_back(mk(0,    0, 0, 0, 0, 0, 0, 0, 31));
    va.push_back(mk(1,    0, 0, 0, 0, 0, 0, 0, 31));
    va.push_back(mk(2,    1, 0, 0, 0, 0, 0, 0, 31));
    va.push_back(mk(3,    1, 0, 0, 0, 0, 0, 0, 31));
    va.push_back(mk(4,    0, 0, 0, 0, 0, 0, 0, 31));
    va.push_back(mk(15,   1, 0, 0, 0, 0, 0, 0, 31));
    va.push_back(mk(16,   0, 1, 0, 0, 1, 0, 0, 31));
    va.push_back(mk(17,   0, 1, 0, 0, 0, 0, 0, 31));
    va.push_back(mk(31,   1, 1, 0, 0, 0, 0, 0, 31));
    va.push_back(mk(32,   0, 0, 0, 0, 0, 1, 0, 30));
    va.push_back(mk(48,   0, 1, 0, 0, 1, 0, 0, 30));
    va.push_back(mk(992,  0, 0, 0, 1, 0, 1, 0, 0));
    va.push_back(mk(1023, 1, 1, 0, 1, 0, 0, 0, 0));
    va.push_back(mk(1024, 0, 0, 1, 1, 0, 1, 0, 31));
    va.push_back(mk(1025, 0, 0, 1, 1, 0, 0, 0, 31));
    va.push_back(mk(1500, 0, 1, 1, 1, 0, 0, 0, 17));
    va.push_back(mk(1640, 0, 0, 1, 1, 0, 0, 0, 12));
    va.push_back(mk(2016, 0, 0, 1, 0, 0, 1, 0, 0));
    va.push_back(mk(2047, 1, 1, 1, 0, 0, 0, 0, 0));
    va.push_back(mk(2048, 0, 0, 0, 0, 0, 1, 1, 31));
    va.push_back(mk(2049, 0, 0, 0, 0, 0, 0, 0, 31));

    vb.push_back(mk(0,    0, 0, 0, 0, 0, 0, 0, 15));
    vb.push_back(mk(1,    1, 0, 0, 0, 0, 0, 0, 15));
    vb.push_back(mk(2,    0, 1, 0, 0, 1, 0, 0, 15));
    vb.push_back(mk(3,    1, 1, 0, 0, 0, 0, 0, 15));
    vb.push_back(mk(4,    0, 0, 0, 0, 0, 1, 0, 14));
    vb.push_back(mk(60,   0, 0, 0, 1, 0, 1, 0, 0));
    vb.push_back(mk(64,   0, 0, 1, 1, 0, 1, 0, 15));
    vb.push_back(mk(124,  0, 0, 1, 0, 0, 1, 0, 0));
    vb.push_back(mk(128,  0, 0, 0, 0, 0, 1, 1, 15));
    vb.push_back(mk(129,  1, 0, 0, 0, 0, 0, 0, 15));

    reset = 1'b0;
    set_en(1'b0);
    repeat (3) @(posedge clk);
    #1 chk_idle("in_reset");

    // Release reset with en low: generator must stay parked.
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_idle("released_en_low");

    // Three full frames from a clean start, continuous checks running.
    fs_cnt = 0;
    mon_on = 1'b1;
    set_en(1'b1);
    run(6145);
    mon_on = 1'b0;
    chk("frame_starts_in_3_frames", 32'(fs_cnt), 32'd3);

    // Restart, then drop en mid right slot (bit_idx=12 at edge 1640).
    @(negedge clk) set_en(1'b0);
    @(negedge clk) set_en(1'b1);
    run(1640);
    @(negedge clk) set_en(1'b0);
    @(posedge clk);
    #1 chk_idle("en_drop");
    mon_on = 1'b1;
    @(negedge clk) set_en(1'b1);
    run(2049);
    mon_on = 1'b0;

    // Asynchronous reset between clk edges mid-frame.
    @(negedge clk) set_en(1'b0);
    @(negedge clk) set_en(1'b1);
    run(1500);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_idle("async_reset");
    repeat (2) @(negedge clk);
    mon_on = 1'b1;
    @(negedge clk) reset = 1'b1;
    run(2049);
    mon_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
